// File: rtl/spi_master_multi_if.sv
// Control and pin bundle for spi_master_multi.
// master is the SPI controller side; slave is the host/pin side.
interface spi_master_multi_if #(
    parameter int DATA_W = 8,
    parameter int NUM_CS = 4,
    parameter int DIV_W  = 8
);
    localparam int CS_W = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;

    logic              start;
    logic [DATA_W-1:0] tx_data;
    logic [CS_W-1:0]   cs_sel;
    logic              cpol;
    logic              cpha;
    logic              lsb_first;
    logic [DIV_W-1:0]  clk_div;
    logic [DATA_W-1:0] rx_data;
    logic              busy;
    logic              done;
    logic              spi_sclk;
    logic              spi_mosi;
    logic              spi_miso;
    logic [NUM_CS-1:0] spi_cs_n;

    modport master (
        input  start, tx_data, cs_sel, cpol, cpha, lsb_first,
        input  clk_div, spi_miso,
        output rx_data, busy, done, spi_sclk, spi_mosi, spi_cs_n
    );

    modport slave (
        output start, tx_data, cs_sel, cpol, cpha, lsb_first,
        output clk_div, spi_miso,
        input  rx_data, busy, done, spi_sclk, spi_mosi, spi_cs_n
    );
endinterface

// File: rtl/spi_master_multi.sv
// SPI master: runtime mode, bit order, SCLK divider and target select.
// All outputs come straight from registers.
module spi_master_multi #(
    parameter int DATA_W = 8,
    parameter int NUM_CS = 4,
    parameter int DIV_W  = 8
) (
    input logic                clk,
    input logic                rst,
    spi_master_multi_if.master bus
);
    localparam int BC_W = $clog2(2 * DATA_W) + 1;
    localparam logic [BC_W-1:0] LAST_T = BC_W'(2 * DATA_W - 1);

    typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_t;

    state_t            state_q, state_d;
    logic [DIV_W-1:0]  cnt_q, cnt_d, div_q, div_d, div_in;
    logic [BC_W-1:0]   bit_q, bit_d;
    logic [DATA_W-1:0] tx_q, tx_d, rx_q, rx_d, rdata_q, rdata_d;
    logic [DATA_W-1:0] tx_shl, rx_shl, first_shl;
    logic              cpha_q, cpha_d, lsb_q, lsb_d;
    logic              sclk_q, sclk_d, mosi_q, mosi_d;
    logic              busy_q, busy_d, done_q, done_d;
    logic              tx_bit, first_bit;
    logic [NUM_CS-1:0] cs_q, cs_d, cs_dec;

    assign div_in    = (bus.clk_div == '0) ? DIV_W'(1) : bus.clk_div;
    assign first_bit = bus.lsb_first ? bus.tx_data[0]
                                     : bus.tx_data[DATA_W-1];
    assign first_shl = bus.lsb_first ? (bus.tx_data >> 1)
                                     : (bus.tx_data << 1);
    assign tx_bit    = lsb_q ? tx_q[0] : tx_q[DATA_W-1];
    assign tx_shl    = lsb_q ? (tx_q >> 1) : (tx_q << 1);
    assign rx_shl    = lsb_q ? {bus.spi_miso, rx_q[DATA_W-1:1]}
                             : {rx_q[DATA_W-2:0], bus.spi_miso};

    assign bus.spi_sclk = sclk_q;
    assign bus.spi_mosi = mosi_q;
    assign bus.spi_cs_n = cs_q;
    assign bus.rx_data  = rdata_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            div_q   <= DIV_W'(1);
            bit_q   <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            rdata_q <= '0;
            cpha_q  <= 1'b0;
            lsb_q   <= 1'b0;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cs_q    <= '1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            rdata_q <= rdata_d;
            cpha_q  <= cpha_d;
            lsb_q   <= lsb_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            cs_q    <= cs_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        bit_d   = bit_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        rdata_d = rdata_q;
        cpha_d  = cpha_q;
        lsb_d   = lsb_q;
        sclk_d  = sclk_q;
        mosi_d  = mosi_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        cs_d    = cs_q;
        // Out-of-range selects leave every line high.
        cs_dec  = '1;
        for (int i = 0; i < NUM_CS; i++)
            if (int'(bus.cs_sel) == i) cs_dec[i] = 1'b0;

        unique case (state_q)
            IDLE: begin
                sclk_d = bus.cpol;
                cs_d   = '1;
                busy_d = 1'b0;
                // The done cycle is still IDLE; a start there is dropped.
                if (bus.start && !done_q) begin
                    state_d = SETUP;
                    busy_d  = 1'b1;
                    cs_d    = cs_dec;
                    div_d   = div_in;
                    cnt_d   = div_in - 1'b1;
                    cpha_d  = bus.cpha;
                    lsb_d   = bus.lsb_first;
                    tx_d    = bus.tx_data;
                    if (!bus.cpha) begin
                        mosi_d = first_bit;
                        tx_d   = first_shl;
                    end
                end
            end
            SETUP: begin
                if (cnt_q == '0) begin
                    state_d = XFER;
                    cnt_d   = div_q - 1'b1;
                    bit_d   = '0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            XFER: begin
                if (cnt_q == '0) begin
                    sclk_d = ~sclk_q;
                    bit_d  = bit_q + 1'b1;
                    cnt_d  = div_q - 1'b1;
                    // bit_q even means this is an odd (leading) toggle.
                    if (bit_q[0] == cpha_q) begin
                        rx_d = rx_shl;
                    end else if (bit_q != LAST_T) begin
                        mosi_d = tx_bit;
                        tx_d   = tx_shl;
                    end
                    if (bit_q == LAST_T) state_d = HOLD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            HOLD: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    cs_d    = '1;
                    rdata_d = rx_q;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_spi_master_multi.sv
// Directed + randomized bench for spi_master_multi with a behavioural
// SPI slave and end-to-end expected values.
module tb_spi_master_multi;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    spi_master_multi_if #(.DATA_W(8), .NUM_CS(4), .DIV_W(8)) ifa ();
    spi_master_multi_if #(.DATA_W(16), .NUM_CS(1), .DIV_W(8)) ifb ();

    spi_master_multi #(.DATA_W(8), .NUM_CS(4), .DIV_W(8)) dut_a (
        .clk(clk), .rst(rst), .bus(ifa.master));
    spi_master_multi #(.DATA_W(16), .NUM_CS(1), .DIV_W(8)) dut_b (
        .clk(clk), .rst(rst), .bus(ifb.master));

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Behavioural slave on bus A: tracks SPI edges, shifts out s_word,
    // records every MOSI bit it samples (first bit ends up in cap[7]).
    logic       s_lb = 1'b1, s_cpol = 1'b0, s_cpha = 1'b0, s_lsb = 1'b0;
    logic       s_miso = 1'b0;
    logic [7:0] s_word = 8'h00, cap = 8'h00;
    int         s_n = 0, cap_n = 0;
    logic       prev_sclk = 1'b0, prev_act = 1'b0;
    wire        act  = (ifa.spi_cs_n != 4'hF);
    wire        lead = (ifa.spi_sclk != s_cpol);

    function automatic logic sbit(input logic [7:0] w, input logic lsb,
                                  input int n);
        if (n > 7) return 1'b0;
        return lsb ? w[n] : w[7-n];
    endfunction

    assign ifa.spi_miso = s_lb ? ifa.spi_mosi : s_miso;
    assign ifb.spi_miso = ifb.spi_mosi;

    always @(negedge clk) begin
        prev_sclk <= ifa.spi_sclk;
        prev_act  <= act;
        if (act && !prev_act) begin
            s_n   <= 0;
            cap   <= 8'h00;
            cap_n <= 0;
            if (!s_cpha) s_miso <= sbit(s_word, s_lsb, 0);
        end else if (act && ifa.spi_sclk != prev_sclk) begin
            if (lead ^ s_cpha) begin
                cap   <= {cap[6:0], ifa.spi_mosi};
                cap_n <= cap_n + 1;
                if (s_cpha) s_n <= s_n + 1;
            end else if (!s_cpha) begin
                s_n    <= s_n + 1;
                s_miso <= sbit(s_word, s_lsb, s_n + 1);
            end else begin
                s_miso <= sbit(s_word, s_lsb, s_n);
            end
        end
    end

    task automatic run_a(input logic [7:0] tx, input logic [7:0] sw,
                         input logic lb, input logic cpol,
                         input logic cpha, input logic lsb,
                         input logic [7:0] div, input logic [1:0] cs,
                         input string tag);
        int d, lat, n, tg;
        logic [3:0] cs_exp;
        logic [7:0] exp_bits;
        logic cs_ok, got, ps, pb;
        d   = (div == 8'd0) ? 1 : int'(div);
        lat = (2 * 8 + 2) * d + 1;
        cs_exp = 4'hF;
        cs_exp[cs] = 1'b0;
        exp_bits = 8'h00;
        for (int i = 0; i < 8; i++)
            exp_bits = {exp_bits[6:0], lsb ? tx[i] : tx[7-i]};
        @(negedge clk);
        s_word = sw; s_lb = lb; s_cpol = cpol; s_cpha = cpha; s_lsb = lsb;
        ifa.tx_data = tx; ifa.cpol = cpol; ifa.cpha = cpha;
        ifa.lsb_first = lsb; ifa.clk_div = div; ifa.cs_sel = cs;
        ifa.start = 1'b1;
        n = 0; tg = 0; cs_ok = 1'b1; got = 1'b0; ps = 1'b0; pb = 1'b0;
        while (n < lat + 20) begin
            @(negedge clk);
            n++;
            ifa.start = 1'b0;
            if (ifa.done) begin
                got = 1'b1;
                break;
            end
            if (ifa.busy && ifa.spi_cs_n !== cs_exp) cs_ok = 1'b0;
            if (ifa.busy && pb && ifa.spi_sclk !== ps) tg++;
            ps = ifa.spi_sclk;
            pb = ifa.busy;
        end
        chk({tag, " done"}, 32'(got), 32'd1);
        chk({tag, " latency"}, n, lat);
        chk({tag, " cs_n"}, 32'(cs_ok), 32'd1);
        chk({tag, " toggles"}, tg, 16);
        chk({tag, " busy@done"}, 32'(ifa.busy), 32'd1);
        chk({tag, " cs_rel"}, 32'(ifa.spi_cs_n), 32'hF);
        chk({tag, " sclk_idle"}, 32'(ifa.spi_sclk), 32'(cpol));
        chk({tag, " rx"}, 32'(ifa.rx_data), 32'(lb ? tx : sw));
        chk({tag, " mosi_bits"}, 32'(cap), 32'(exp_bits));
        chk({tag, " mosi_cnt"}, cap_n, 8);
        @(negedge clk);
        chk({tag, " busy_end"}, 32'(ifa.busy), 32'd0);
        chk({tag, " done_1cyc"}, 32'(ifa.done), 32'd0);
    endtask

    task automatic run_b(input logic [15:0] tx, input logic cs,
                         input logic [7:0] div, input string tag);
        int d, lat, n, low, bz;
        logic got;
        d   = (div == 8'd0) ? 1 : int'(div);
        lat = (2 * 16 + 2) * d + 1;
        @(negedge clk);
        ifb.tx_data = tx; ifb.cpol = 1'b0; ifb.cpha = 1'b1;
        ifb.lsb_first = 1'b0; ifb.clk_div = div; ifb.cs_sel = cs;
        ifb.start = 1'b1;
        n = 0; low = 0; bz = 0; got = 1'b0;
        while (n < lat + 20) begin
            @(negedge clk);
            n++;
            ifb.start = 1'b0;
            if (ifb.done) begin
                got = 1'b1;
                break;
            end
            if (ifb.busy) bz++;
            if (ifb.spi_cs_n == 1'b0) low++;
        end
        chk({tag, " done"}, 32'(got), 32'd1);
        chk({tag, " latency"}, n, lat);
        chk({tag, " rx"}, 32'(ifb.rx_data), 32'(tx));
        chk({tag, " cs_low"}, low, cs ? 0 : bz);
        chk({tag, " sclk_idle"}, 32'(ifb.spi_sclk), 32'd0);
    endtask

    initial begin
        logic [7:0] r_tx, r_sw, r_div;
        logic [1:0] r_cs;
        int n, dones, falls, hi_run, min_gap, last_d, extra, tg;
        logic gap_ok, pa, pd, saw, ps, pb;

        ifa.start = 1'b0; ifa.tx_data = 8'h00; ifa.cs_sel = 2'd0;
        ifa.cpol = 1'b1; ifa.cpha = 1'b0; ifa.lsb_first = 1'b0;
        ifa.clk_div = 8'd1;
        ifb.start = 1'b0; ifb.tx_data = 16'h0; ifb.cs_sel = 1'b0;
        ifb.cpol = 1'b0; ifb.cpha = 1'b1; ifb.lsb_first = 1'b0;
        ifb.clk_div = 8'd1;

        repeat (2) @(negedge clk);
        chk("rst cs_n", 32'(ifa.spi_cs_n), 32'hF);
        chk("rst sclk", 32'(ifa.spi_sclk), 32'd0);
        chk("rst mosi", 32'(ifa.spi_mosi), 32'd0);
        chk("rst rx", 32'(ifa.rx_data), 32'd0);
        chk("rst busy", 32'(ifa.busy), 32'd0);
        chk("rst done", 32'(ifa.done), 32'd0);
        chk("rst b cs_n", 32'(ifb.spi_cs_n), 32'd1);
        rst = 1'b0;
        @(negedge clk);
        chk("sclk follows cpol", 32'(ifa.spi_sclk), 32'd1);
        ifa.cpol = 1'b0;
        @(negedge clk);
        chk("sclk live cpol", 32'(ifa.spi_sclk), 32'd0);

        run_a(8'hA5, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'd2, 2'd1, "mode0");

        ifa.cpol = 1'b1;
        @(negedge clk);
        chk("mode3 idle high", 32'(ifa.spi_sclk), 32'd1);
        run_a(8'h3C, 8'h96, 1'b0, 1'b1, 1'b1, 1'b1, 8'd3, 2'd2, "mode3");

        r_tx = 8'($urandom);
        run_a(r_tx, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 2'd0, "div0");

        for (int k = 0; k < 6; k++) begin
            r_tx  = 8'($urandom);
            r_sw  = 8'($urandom);
            r_div = 8'($urandom_range(0, 3));
            r_cs  = 2'($urandom_range(0, 3));
            run_a(r_tx, r_sw, 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), r_div, r_cs, "rand");
        end

        // start held high: one frame every L+2 cycles, L = 18*D.
        @(negedge clk);
        ifa.cpol = 1'b0; ifa.cpha = 1'b0; ifa.lsb_first = 1'b0;
        ifa.clk_div = 8'd1; ifa.cs_sel = 2'd2; ifa.tx_data = 8'h5C;
        s_lb = 1'b1;
        ifa.start = 1'b1;
        n = 0; dones = 0; falls = 0; hi_run = 0; min_gap = 1000;
        last_d = 0; gap_ok = 1'b1; pa = 1'b0; pd = 1'b0;
        while (n < 200) begin
            @(negedge clk);
            n++;
            if (act && !pa) begin
                falls++;
                if (falls > 1 && hi_run < min_gap) min_gap = hi_run;
                hi_run = 0;
            end
            if (!act) hi_run++;
            if (ifa.done && pd) gap_ok = 1'b0;
            if (ifa.done) begin
                dones++;
                if (dones > 1 && n - last_d != 20) gap_ok = 1'b0;
                last_d = n;
            end
            pa = act;
            pd = ifa.done;
            if (dones == 3) begin
                ifa.start = 1'b0;
                break;
            end
        end
        extra = 0;
        repeat (40) begin
            @(negedge clk);
            if (ifa.done) extra++;
            if (act && !pa) falls++;
            pa = act;
        end
        chk("b2b dones", dones, 3);
        chk("b2b frames", falls, 3);
        chk("b2b cs gap", 32'(min_gap >= 1), 32'd1);
        chk("b2b spacing", 32'(gap_ok), 32'd1);
        chk("b2b extra done", extra, 0);

        // Reset while the fifth bit is on the wire.
        @(negedge clk);
        ifa.clk_div = 8'd2; ifa.cs_sel = 2'd0; ifa.tx_data = 8'h5A;
        ifa.start = 1'b1;
        n = 0; tg = 0; ps = 1'b0; pb = 1'b0;
        while (n < 200 && tg < 8) begin
            @(negedge clk);
            n++;
            ifa.start = 1'b0;
            if (ifa.busy && pb && ifa.spi_sclk !== ps) tg++;
            ps = ifa.spi_sclk;
            pb = ifa.busy;
        end
        chk("abort reached bit4", tg, 8);
        chk("abort pre busy", 32'(ifa.busy), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("abort cs_n", 32'(ifa.spi_cs_n), 32'hF);
        chk("abort busy", 32'(ifa.busy), 32'd0);
        chk("abort rx", 32'(ifa.rx_data), 32'd0);
        chk("abort sclk", 32'(ifa.spi_sclk), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        saw = 1'b0;
        repeat (60) begin
            @(negedge clk);
            if (ifa.done) saw = 1'b1;
        end
        chk("abort no done", 32'(saw), 32'd0);
        chk("abort rx hold", 32'(ifa.rx_data), 32'd0);

        r_div = 8'($urandom_range(1, 3));
        run_b(16'h1234, 1'b0, r_div, "w16");
        run_b(16'($urandom), 1'b1, 8'd2, "w16 cs_oor");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/spi_master_multi.md
SPI_MASTER_MULTI -- requirements
Module: spi_master_multi

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning the frame width in bits (legal 4..32).
REQ-002 The block SHALL have parameter NUM_CS, default 4, meaning the number of chip-select lines (legal 1..16).
REQ-003 The block SHALL have parameter DIV_W, default 8, meaning the width of the runtime divider input.
REQ-004 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-005 The block SHALL have port clk, input, width 1, the system clock.
REQ-006 The block SHALL have port rst, input, width 1, the asynchronous active-high reset.
REQ-007 The block SHALL have port start, input, width 1, the transaction request.
REQ-008 The block SHALL have port tx_data, input, width DATA_W, the frame to send.
REQ-009 The block SHALL have port cs_sel, input, width max(1,$clog2(NUM_CS)), the target slave index.
REQ-010 The block SHALL have ports cpol, cpha and lsb_first, each input, width 1, selecting SPI mode and bit order.
REQ-011 The block SHALL have port clk_div, input, width DIV_W, giving the SCLK half-period D in clk cycles; a value of 0 SHALL be treated as D=1.
REQ-012 The block SHALL have port rx_data, output, width DATA_W, the last received frame.
REQ-013 The block SHALL have ports busy and done, each output, width 1; done is a one-cycle completion pulse.
REQ-014 The block SHALL have ports spi_sclk, spi_mosi and spi_miso (in), each width 1, and spi_cs_n, output, width NUM_CS, active low.

Function
REQ-015 The FSM SHALL have states IDLE, SETUP, XFER and HOLD, and all outputs SHALL be registered.
REQ-016 start SHALL be sampled only in IDLE; tx_data, cs_sel, cpol, cpha, lsb_first and D SHALL be latched on acceptance and held until return to IDLE.
REQ-017 start asserted outside IDLE SHALL be ignored, with no queueing.
REQ-018 In IDLE, spi_sclk SHALL equal the live cpol input, spi_cs_n SHALL be all ones, and busy SHALL be 0.
REQ-019 In SETUP, which lasts D cycles, spi_cs_n[cs_sel] SHALL be 0 and spi_sclk SHALL equal the latched cpol.
REQ-020 With cpha=0, the first bit SHALL be driven on spi_mosi on SETUP entry.
REQ-021 XFER SHALL last 2*DATA_W half-periods of D cycles each, with spi_sclk toggling at the end of each half-period.
REQ-022 With cpha=0, spi_miso SHALL be sampled on odd toggles (leading edges), and the next bit SHALL be driven on even toggles.
REQ-023 With cpha=1, the bit SHALL be driven on odd toggles, and spi_miso SHALL be sampled on even toggles.
REQ-024 Bit order SHALL be MSB first when lsb_first=0 and LSB first when lsb_first=1, applied identically to TX and RX.
REQ-025 The received word SHALL be assembled in the same bit order as transmission.
REQ-026 After the final toggle, spi_sclk SHALL be back at cpol, and the block SHALL enter HOLD for D cycles with CS still asserted.
REQ-027 On HOLD exit, the block SHALL deassert CS, update rx_data, pulse done for 1 cycle and return to IDLE.
REQ-028 Latency from the start-sampled edge to done high SHALL be (2*DATA_W+2)*D+1 clk cycles.
REQ-029 busy SHALL be high from the cycle after acceptance through the done cycle inclusive.
REQ-030 A start asserted in the done cycle SHALL be ignored; back-to-back transactions SHALL have CS high for at least 1 cycle.
REQ-031 An out-of-range cs_sel (>= NUM_CS) SHALL run a full transaction with all CS lines high, and rx_data SHALL still update.
REQ-032 The half-period counter SHALL be DIV_W bits wide and the bit counter $clog2(2*DATA_W)+1 bits wide, with no wrap within a frame.
REQ-033 rx_data SHALL hold its value between transactions.

Reset
REQ-034 On rst high, the block SHALL go to IDLE immediately and asynchronously.
REQ-035 Reset SHALL drive spi_cs_n to all ones, spi_sclk to 0, spi_mosi to 0, rx_data to 0, and busy and done to 0.
REQ-036 Reset mid-transaction SHALL abort the transaction with no done pulse, and rx_data SHALL read 0.
REQ-037 After rst falls, spi_sclk SHALL follow cpol from the first clk edge.

Verification
REQ-038 DATA_W=8, mode 0, MSB first, D=2, cs_sel=1, tx=0xA5, loopback MOSI->MISO -> rx_data=0xA5, cs_n=4'b1101 during the transfer, done 37 cycles after start.
REQ-039 Mode 3 (cpol=1, cpha=1), LSB first, tx=0x3C, slave model returns 0x96 -> MOSI bits 0,0,1,1,1,1,0,0 in order, rx_data=0x96, sclk idles high.
REQ-040 clk_div=0 -> behaves as D=1: SCLK period 2 clk cycles, done 19 cycles after start.
REQ-041 start held high continuously for 3 transactions -> exactly 3 done pulses, CS high for at least 1 cycle between frames, start during busy ignored.
REQ-042 rst asserted in XFER bit 4 -> cs_n=all ones and busy=0 asynchronously, no done pulse, rx_data=0.
REQ-043 DATA_W=16, NUM_CS=1, mode 1, tx=0x1234 with loopback -> rx_data=0x1234, and cs_sel=1 (out of range) -> cs_n stays 1 while done still pulses.
